mont_arbiter: RTL

- Shares one `montgomery3` multiplier between two requesters with a round-robin req/grant handshake.
- Typical requesters: the two ladder multiplier slots, or a ladder plus a pre/post-processing unit.
- On grant, latches the winner's operands, pulses the multiplier start, waits for done, then returns the product with a one-cycle done strobe.
- A watchdog counter aborts a multiplication that never completes.

---
 rtl/mont_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mont_arbiter.sv
// mont_arbiter: shares one montgomery3 multiplier between two requesters
// using a round-robin request/grant handshake and a watchdog timeout.
//
// Ports:
//   clk, resetn                 clock and synchronous active-low reset
//   req0/req1                   level requests, held until the matching done
//   in_a0/in_b0, in_a1/in_b1    per-requester operands, sampled on the grant edge
//   in_m                        shared modulus, forwarded to mult_m
//   gnt0/gnt1                   registered grant, one-hot or zero
//   done0/done1                 one-cycle completion strobe to the grantee
//   err                         set together with done when the multiply timed out
//   result                      product register, held until the next capture
//   busy                        high in any state other than IDLE
//   mult_*                      multiplier control, operands and response
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | multiplier held in reset, arbitrating pending requests
// LAUNCH | operands latched, one-cycle start pulse, watchdog cleared
// WAIT   | waiting for mult_done, watchdog counting
// RESP   | done (and err on timeout) strobed to the grantee

module mont_arbiter #(
    parameter int TIMEOUT = 2047
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          req0,
    input  logic          req1,
    input  logic [1023:0] in_a0,
    input  logic [1023:0] in_b0,
    input  logic [1023:0] in_a1,
    input  logic [1023:0] in_b1,
    input  logic [1023:0] in_m,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic          err,
    output logic [1023:0] result,
    output logic          busy,
    output logic          mult_resetn,
    output logic          mult_start,
    output logic [1023:0] mult_a,
    output logic [1023:0] mult_b,
    output logic [1023:0] mult_m,
    input  logic [1023:0] mult_result,
    input  logic          mult_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [10:0] TIMEOUT_CNT = 11'(TIMEOUT);

    state_t        state;
    logic [10:0]   cnt;
    logic          last;
    logic          err_r;
    logic [1023:0] op_a;
    logic [1023:0] op_b;
    logic          win1;

    // Requester 1 wins when it is alone, or on a tie when 0 was served last.
    assign win1 = req1 & (~req0 | ~last);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;
            err_r  <= 1'b0;
            result <= '0;
            last   <= 1'b1;
            cnt    <= '0;
            op_a   <= '0;
            op_b   <= '0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    gnt0 <= 1'b0;
                    gnt1 <= 1'b0;
                    if (req0 | req1) begin
                        if (win1) begin
                            gnt1 <= 1'b1;
                            op_a <= in_a1;
                            op_b <= in_b1;
                            last <= 1'b1;
                        end else begin
                            gnt0 <= 1'b1;
                            op_a <= in_a0;
                            op_b <= in_b0;
                            last <= 1'b0;
                        end
                        state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // mult_done wins over a coincident watchdog expiry
                    if (mult_done) begin
                        result <= mult_result;
                        err_r  <= 1'b0;
                        done0  <= gnt0;
                        done1  <= gnt1;
                        state  <= RESP;
                    end else if (cnt == TIMEOUT_CNT) begin
                        err_r <= 1'b1;
                        done0 <= gnt0;
                        done1 <= gnt1;
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end
                RESP: begin
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign err         = err_r & (state == RESP);
    assign busy        = (state != IDLE);
    assign mult_start  = (state == LAUNCH);
    assign mult_resetn = resetn & (state != IDLE);
    assign mult_a      = op_a;
    assign mult_b      = op_b;
    assign mult_m      = in_m;

endmodule
